debouncer_sync: RTL and testbench
=================================

Name: debouncer_sync

Overview:
- Single-input push-button debouncer.
- Synchronises one raw mechanical button level into the clk domain and filters contact bounce.
- Outputs a clean level plus single-cycle rise/fall strobes.
- One instance per button; sits between FPGA pins and the menu/option control logic, running on the fast system clock.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on btn; legal range 2..4.
- STABLE_CYCLES, 1000000, consecutive clk cycles the synchronised input must differ from dbd before dbd changes (10 ms at 100 MHz); must be >= 1.
- CNT_WIDTH, 20, stability counter width; must satisfy 2^CNT_WIDTH > STABLE_CYCLES-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn  input  1  raw asynchronous button level (1 = pressed).
- dbd  output 1  debounced button level, registered.
- dbd_rise  output 1  one-cycle pulse when dbd goes 0->1.
- dbd_fall  output 1  one-cycle pulse when dbd goes 1->0.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset: on any rising edge of clk with rst=1:
  - all synchroniser flops, the counter, dbd, dbd_rise and dbd_fall clear to 0.
  - This applies mid-count too; any partial count is discarded.
- Synchroniser:
  - SYNC_STAGES-flop shift chain on btn.
  - The last stage, s, is the only value used downstream.
  - btn never feeds combinational logic directly.
- Stability counter cnt (CNT_WIDTH bits):
  - If s == dbd: cnt <= 0.
  - If s != dbd and cnt < STABLE_CYCLES-1: cnt <= cnt+1, dbd holds.
  - If s != dbd and cnt == STABLE_CYCLES-1: dbd <= s, cnt <= 0.
  - Net effect: dbd changes on the STABLE_CYCLES-th consecutive edge where s differs from dbd.
- Glitch rejection: any single cycle of s == dbd during a count resets cnt to 0, and the count restarts from scratch.
- Latency:
  - A clean btn step held steady changes dbd exactly SYNC_STAGES + STABLE_CYCLES rising edges after the first edge that samples the new btn value.
  - With the defaults, that is 1000002 cycles.
- STABLE_CYCLES = 1: dbd follows s with one cycle of delay and no filtering; the counter stays 0.
- Strobes:
  - dbd_rise and dbd_fall are registered and asserted on the same edge that dbd changes.
  - Each is high for exactly one cycle; they are never both high.
  - Both are 0 in every other cycle.
- Symmetric filtering: press and release use the same STABLE_CYCLES threshold.
- The counter never wraps: it is bounded by STABLE_CYCLES-1 by construction.
- No combinational path from any input to any output.

Test Plan:
(bench overrides STABLE_CYCLES=8, SYNC_STAGES=2)
1. Reset behaviour: assert rst 3 cycles with btn=1 -> dbd=0, dbd_rise=0, dbd_fall=0 throughout; after release, dbd rises exactly 10 edges after the first edge sampling btn=1.
2. Clean press then release:
   - Set btn 0->1 and hold 20 cycles -> dbd=1 after 10 edges, dbd_rise high exactly 1 cycle on that edge.
   - Then btn 1->0 -> dbd=0 after 10 edges, dbd_fall high 1 cycle.
3. Bounce rejection:
   - btn toggles 1,0,1,0 with each level held 3 cycles, then settles at 1 -> dbd stays 0 during the bounce.
   - dbd goes 1 exactly 10 edges after the final 0->1; exactly one dbd_rise pulse.
4. Near-threshold glitch: btn=1 for 7 cycles, 0 for 1 cycle, then 1 held -> no change at the 7-cycle run; dbd rises 10 edges after the last 0->1.
5. Reset mid-count: btn=1 held, pulse rst for 1 cycle at count 5 -> dbd stays 0; counting restarts and dbd rises 8 edges after the synchroniser re-propagates btn=1 (10 edges after rst deasserts).
6. STABLE_CYCLES=1 instance: btn 0->1 -> dbd=1 three edges later, with one dbd_rise pulse.

Source files
------------

// File: rtl/debouncer_sync.sv
// Push-button debouncer: synchronises a raw button level into clk and
// filters contact bounce, producing a clean level plus rise/fall strobes.
//
// Ports:
//   clk      - system clock, all logic on the rising edge
//   rst      - synchronous active-high reset
//   btn      - raw asynchronous button level (1 = pressed)
//   dbd      - debounced button level, registered
//   dbd_rise - one-cycle pulse on the edge dbd goes 0->1
//   dbd_fall - one-cycle pulse on the edge dbd goes 1->0
//
// Parameters:
//   SYNC_STAGES   - synchroniser depth on btn (2..4)
//   STABLE_CYCLES - consecutive cycles s must differ from dbd (>= 1)
//   CNT_WIDTH     - counter width, 2**CNT_WIDTH > STABLE_CYCLES-1
module debouncer_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic dbd,
    output logic dbd_rise,
    output logic dbd_fall
);

    // Count value on which the STABLE_CYCLES-th mismatching edge lands.
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_WIDTH-1:0]   cnt;

    // Only the last synchroniser stage is used downstream.
    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    // Any cycle where s agrees with dbd discards the partial count, so a
    // single glitch restarts filtering. The counter stops at LAST and
    // therefore never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            dbd      <= 1'b0;
            dbd_rise <= 1'b0;
            dbd_fall <= 1'b0;
        end else begin
            dbd_rise <= 1'b0;
            dbd_fall <= 1'b0;
            if (s == dbd) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt      <= '0;
                dbd      <= s;
                dbd_rise <= s;
                dbd_fall <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debouncer_sync.sv
// Directed bench for debouncer_sync: expected dbd transitions are queued
// with the edge they must land on and checked every cycle.
module tb_debouncer_sync;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic btn1 = 1'b0;
    logic dbd, dbd_rise, dbd_fall;
    logic dbd1, dbd1_rise, dbd1_fall;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int   at;
        logic lvl;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    logic ed0 = 1'b0;
    logic ed1 = 1'b0;

    always #5 clk = ~clk;

    debouncer_sync #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(8),
        .CNT_WIDTH    (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .dbd     (dbd),
        .dbd_rise(dbd_rise),
        .dbd_fall(dbd_fall)
    );

    debouncer_sync #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(1),
        .CNT_WIDTH    (1)
    ) dut1 (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn1),
        .dbd     (dbd1),
        .dbd_rise(dbd1_rise),
        .dbd_fall(dbd1_fall)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b",
                   tag, cyc, obs, exp);
        end
    endtask

    // Transition expected offs edges after the last completed edge; the
    // next edge (offs=1) is the first one sampling the new btn level.
    task automatic exp0(input int offs, input logic lvl);
        ev_t e;
        e.at  = cyc + offs;
        e.lvl = lvl;
        q0.push_back(e);
    endtask

    task automatic exp1(input int offs, input logic lvl);
        ev_t e;
        e.at  = cyc + offs;
        e.lvl = lvl;
        q1.push_back(e);
    endtask

    task automatic tick(input logic b, input logic b1, input logic r);
        logic er0, ef0, er1, ef1;
        ev_t  e;
        btn  = b;
        btn1 = b1;
        rst  = r;
        @(posedge clk);
        #1;
        cyc++;
        er0 = 1'b0;
        ef0 = 1'b0;
        er1 = 1'b0;
        ef1 = 1'b0;
        if (r) begin
            ed0 = 1'b0;
            ed1 = 1'b0;
        end else begin
            if (q0.size() > 0 && q0[0].at == cyc) begin
                e   = q0.pop_front();
                ed0 = e.lvl;
                er0 = e.lvl;
                ef0 = ~e.lvl;
            end
            if (q1.size() > 0 && q1[0].at == cyc) begin
                e   = q1.pop_front();
                ed1 = e.lvl;
                er1 = e.lvl;
                ef1 = ~e.lvl;
            end
        end
        chk("dbd", dbd, ed0);
        chk("dbd_rise", dbd_rise, er0);
        chk("dbd_fall", dbd_fall, ef0);
        chk("dbd1", dbd1, ed1);
        chk("dbd1_rise", dbd1_rise, er1);
        chk("dbd1_fall", dbd1_fall, ef1);
    endtask

    task automatic hold(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            tick(b, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // 1: reset with btn high, then release
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b1);
        end
        exp0(10, 1'b1);
        hold(14, 1'b1);
        exp0(10, 1'b0);
        hold(14, 1'b0);

        // 2: clean press and release
        exp0(10, 1'b1);
        hold(20, 1'b1);
        exp0(10, 1'b0);
        hold(20, 1'b0);

        // 3: bounce 1,0,1,0 x3 cycles, then settle high
        hold(3, 1'b1);
        hold(3, 1'b0);
        hold(3, 1'b1);
        hold(3, 1'b0);
        exp0(10, 1'b1);
        hold(14, 1'b1);
        exp0(10, 1'b0);
        hold(14, 1'b0);

        // 4: seven-cycle run, one-cycle glitch, then hold high
        hold(7, 1'b1);
        hold(1, 1'b0);
        exp0(10, 1'b1);
        hold(14, 1'b1);
        exp0(10, 1'b0);
        hold(14, 1'b0);

        // 5: reset pulse when the count has reached 5
        hold(7, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        exp0(10, 1'b1);
        hold(14, 1'b1);
        exp0(10, 1'b0);
        hold(14, 1'b0);

        // 6: unfiltered instance follows with pipeline delay only
        exp1(3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 1'b0);
        end
        exp1(3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 1'b0);
        end

        total++;
        assert (q0.size() == 0 && q1.size() == 0)
        else begin
            bad++;
            $error("FAIL pending_events observed=%0d expected=0",
                   q0.size() + q1.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
